iact_glb_sender: RTL
====================

// Module: iact_glb_sender
// PURPOSE
//  Transmit end of the iact address/data valid-ready streams: reads one iact CSC segment
//  (address vector + data vector) from the iact GLB SRAM pair and drives it into the iact
//  router GLB source port. Address and data channels stream independently, each with its
//  own 2-entry output buffer absorbing the 1-cycle SRAM read latency under backpressure.
// PARAMETERS
//  ADDR_W       7   width of one address-vector entry
//  DATA_W       12  width of one data-vector entry
//  ADDR_SRAM_AW 5   address SRAM index width (depth 2**ADDR_SRAM_AW)
//  DATA_SRAM_AW 6   data SRAM index width (depth 2**DATA_SRAM_AW)
// PORTS
//  clk                 in   1              clock, rising edge
//  reset               in   1              asynchronous, active-high
//  start               in   1              begin segment; sampled only in IDLE
//  addr_base           in   ADDR_SRAM_AW   first address SRAM index of segment
//  addr_len            in   ADDR_SRAM_AW+1 number of address entries (0..depth)
//  data_base           in   DATA_SRAM_AW   first data SRAM index of segment
//  data_len            in   DATA_SRAM_AW+1 number of data entries (0..depth)
//  busy                out  1              high in STREAM and DONE
//  done                out  1              1-cycle pulse, segment fully handshaken
//  addr_sram_rd_en     out  1              address SRAM read strobe
//  addr_sram_rd_addr   out  ADDR_SRAM_AW   address SRAM read index
//  addr_sram_rd_data   in   ADDR_W         valid the cycle after addr_sram_rd_en
//  data_sram_rd_en     out  1              data SRAM read strobe
//  data_sram_rd_addr   out  DATA_SRAM_AW   data SRAM read index
//  data_sram_rd_data   in   DATA_W         valid the cycle after data_sram_rd_en
//  iact_address_out_valid out 1  / iact_address_out_ready in 1 / iact_address_out out ADDR_W
//  iact_data_out_valid    out 1  / iact_data_out_ready    in 1 / iact_data_out    out DATA_W
// BEHAVIOUR
//  Reset: state IDLE; all counters, buffers cleared; busy, done, both *_rd_en, both
//   *_out_valid = 0; rd_addr and out data = 0. Reset mid-segment abandons it, no done.
//  FSM: IDLE -start-> STREAM (bases/lens latched) -both channels complete-> DONE -> IDLE.
//   start outside IDLE is ignored; latched bases/lens never change during STREAM.
//  Per channel (identical, independent): issue counter, sent counter, in-flight flag,
//   2-entry FIFO. Issue read in STREAM when issued<len and (fifo_cnt+inflight-pop)<2,
//   pop = out_valid & out_ready this cycle. rd_addr = base+issued, wraps mod SRAM depth.
//  rd_data written into FIFO the cycle after rd_en; out_valid = FIFO non-empty (registered).
//  Latency: start in cycle 0 -> rd_en cycle 1 -> out_valid cycle 3. Ready held high ->
//   one entry per cycle sustained, no bubbles.
//  Handshake: transfer when valid&ready; once valid is high, valid and data hold until
//   accepted; valid never depends combinationally on ready; never drops without transfer.
//  Channel complete when sent==len. len=0: channel complete on STREAM entry, its valid
//   and rd_en never assert. Both len=0: STREAM one cycle, then DONE.
//  done asserts in the cycle after the later of the two final handshakes (DONE state),
//   for exactly one cycle; a start in that cycle is ignored.
//  Simultaneous push and pop on a full FIFO is legal (count unchanged); overflow impossible.
//  Channels never wait on each other; address may finish long before data or vice versa.
// TESTING
//  1 addr_base=0,len=3 (SRAM 5,6,7); data_base=0,len=4 (SRAM 10..13); ready=1 -> addr out
//    5,6,7 in cycles 3-5, data 10..13 in cycles 3-6, done in cycle 7 only.
//  2 same segment, data_ready toggles 1,0,1,0 -> data held stable while ready=0, order
//    10..13 preserved, no duplicate or lost beat, done after 4th data handshake.
//  3 addr_base=30,len=4 (AW=5) -> rd_addr sequence 30,31,0,1.
//  4 addr_len=0,data_len=2 -> address valid never asserts; done after 2nd data beat;
//    both lens 0 -> done 2 cycles after start, no rd_en.
//  5 assert reset during STREAM with valid high, ready=0 -> valids, busy, rd_en low
//    immediately; no done; next start streams new segment from its base correctly.
//  6 start pulsed again mid-STREAM and in DONE cycle -> ignored; exactly one done.

Source files
------------

// File: rtl/iact_glb_sender.sv
// iact GLB sender: streams one iact CSC segment (address + data vectors) from the GLB SRAM
// pair into the router GLB source port over two independent valid/ready channels.

module iact_glb_sender_chan #(
  parameter int W  = 7,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          active,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic [W-1:0]  rd_data,
  input  logic          out_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          complete
);

  logic [AW-1:0] base_r;
  logic [AW:0]   len_r;
  logic [AW:0]   issued_r;
  logic [AW:0]   sent_r;
  logic          inflight_r;
  logic [1:0]    cnt_r;
  logic [W-1:0]  head_r;
  logic [W-1:0]  tail_r;
  logic          pop_s;
  logic [2:0]    occ_s;
  logic [AW+1:0] sent_next_s;

  // An in-flight read already owns a buffer slot, so it counts toward occupancy.
  assign pop_s       = (cnt_r != 2'd0) && out_ready;
  assign occ_s       = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_en       = active && (issued_r < len_r) && (occ_s < 3'd2);
  assign rd_addr     = base_r + issued_r[AW-1:0];
  assign out_valid   = (cnt_r != 2'd0);
  assign out_data    = head_r;
  assign sent_next_s = {1'b0, sent_r} + {{(AW+1){1'b0}}, pop_s};
  assign complete    = (sent_next_s == {1'b0, len_r});

  // Segment latch, issue/sent counters and the 2-entry head/tail output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r     <= '0;
      len_r      <= '0;
      issued_r   <= '0;
      sent_r     <= '0;
      inflight_r <= 1'b0;
      cnt_r      <= 2'd0;
      head_r     <= '0;
      tail_r     <= '0;
    end else if (load) begin
      base_r     <= base;
      len_r      <= len;
      issued_r   <= '0;
      sent_r     <= '0;
      inflight_r <= 1'b0;
      cnt_r      <= 2'd0;
    end else begin
      inflight_r <= rd_en;
      if (rd_en) begin
        issued_r <= issued_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        sent_r <= sent_r + {{AW{1'b0}}, 1'b1};
      end
      // head_r is always the oldest entry and drives the output directly.
      case ({inflight_r, pop_s})
        2'b10: begin
          case (cnt_r)
            2'd0:    head_r <= rd_data;
            2'd1:    tail_r <= rd_data;
            default: tail_r <= tail_r;
          endcase
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          if (cnt_r == 2'd2) begin
            head_r <= tail_r;
          end
          cnt_r <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= rd_data;
          end else begin
            head_r <= rd_data;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

module iact_glb_sender #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 12,
  parameter int ADDR_SRAM_AW = 5,
  parameter int DATA_SRAM_AW = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_SRAM_AW-1:0] addr_base,
  input  logic [ADDR_SRAM_AW:0]   addr_len,
  input  logic [DATA_SRAM_AW-1:0] data_base,
  input  logic [DATA_SRAM_AW:0]   data_len,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_sram_rd_en,
  output logic [ADDR_SRAM_AW-1:0] addr_sram_rd_addr,
  input  logic [ADDR_W-1:0]       addr_sram_rd_data,
  output logic                    data_sram_rd_en,
  output logic [DATA_SRAM_AW-1:0] data_sram_rd_addr,
  input  logic [DATA_W-1:0]       data_sram_rd_data,
  output logic                    iact_address_out_valid,
  input  logic                    iact_address_out_ready,
  output logic [ADDR_W-1:0]       iact_address_out,
  output logic                    iact_data_out_valid,
  input  logic                    iact_data_out_ready,
  output logic [DATA_W-1:0]       iact_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;
  logic   busy_r;
  logic   done_r;
  logic   load_s;
  logic   active_s;
  logic   addr_complete_s;
  logic   data_complete_s;

  assign load_s   = (state_r == IDLE) && start;
  assign active_s = (state_r == STREAM);
  assign busy     = busy_r;
  assign done     = done_r;

  iact_glb_sender_chan #(.W(ADDR_W), .AW(ADDR_SRAM_AW)) u_addr_chan (
    .clk       (clk),
    .rst       (reset),
    .load      (load_s),
    .active    (active_s),
    .base      (addr_base),
    .len       (addr_len),
    .rd_data   (addr_sram_rd_data),
    .out_ready (iact_address_out_ready),
    .rd_en     (addr_sram_rd_en),
    .rd_addr   (addr_sram_rd_addr),
    .out_valid (iact_address_out_valid),
    .out_data  (iact_address_out),
    .complete  (addr_complete_s)
  );

  iact_glb_sender_chan #(.W(DATA_W), .AW(DATA_SRAM_AW)) u_data_chan (
    .clk       (clk),
    .rst       (reset),
    .load      (load_s),
    .active    (active_s),
    .base      (data_base),
    .len       (data_len),
    .rd_data   (data_sram_rd_data),
    .out_ready (iact_data_out_ready),
    .rd_en     (data_sram_rd_en),
    .rd_addr   (data_sram_rd_addr),
    .out_valid (iact_data_out_valid),
    .out_data  (iact_data_out),
    .complete  (data_complete_s)
  );

  // Segment sequencing with registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= STREAM;
            busy_r  <= 1'b1;
          end
        end
        STREAM: begin
          if (addr_complete_s && data_complete_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
